// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD driver: packed-word bit
// positions, FSM state encoding, power-up init bytes and command classifiers.
package lcd_pkg;

  // Bit positions inside the packed 32-bit LCD output word.
  localparam int unsigned LCD_ON_BIT = 31;
  localparam int unsigned LCD_EN_BIT = 10;
  localparam int unsigned LCD_RS_BIT = 9;
  localparam int unsigned LCD_RW_BIT = 8;

  // Driver FSM states.
  typedef enum logic [2:0] {
    StInitWait = 3'd0,
    StIdle     = 3'd1,
    StSetup    = 3'd2,
    StPulse    = 3'd3,
    StHold     = 3'd4,
    StExecWait = 3'd5
  } lcd_state_e;

  // Power-up instruction sequence: 8-bit/2-line x3, display on, clear, entry mode.
  localparam int unsigned LCD_INIT_LEN = 6;
  localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] = '{
    8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06
  };

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

  // A zero cycle count would make a state vanish; clamp it to one cycle.
  function automatic int unsigned eff_cyc(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed state of the LCD driver.
// Counts down to zero and parks there; done_o is high while the count is zero.
module lcd_timer #(
  parameter int unsigned     Width    = 8,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;

  // Load wins over counting; the counter saturates at zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= ResetVal;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Terminal-count flag.
  always_comb begin
    done_o = (cnt_q == '0);
  end

endmodule

// File: rtl/lcd_char_driver.sv
// HD44780 16x2 character LCD driver. Accepts one RS/DATA byte per handshake and
// sequences setup, EN pulse, hold and execution wait so software never toggles EN.
// Optional power-up init sequence is compiled in with `define LCD_INIT_EN.
module lcd_char_driver
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned EN_HIGH_CYC    = 25,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 80000,
  parameter int unsigned INIT_WAIT_CYC  = 750000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        busy_o,
  output logic        init_done_o,
  output logic [31:0] lcd_o
);

  localparam int unsigned MaxCyc = max_u(max_u(max_u(eff_cyc(SETUP_CYC), eff_cyc(EN_HIGH_CYC)),
                                               max_u(eff_cyc(HOLD_CYC), eff_cyc(CMD_WAIT_CYC))),
                                         max_u(eff_cyc(CLEAR_WAIT_CYC), eff_cyc(INIT_WAIT_CYC)));
  localparam int unsigned CntW = $clog2(MaxCyc + 1);

  // Counter loads N-1 on state entry so each timed state lasts exactly N cycles.
  localparam logic [CntW-1:0] SetupLd = CntW'(eff_cyc(SETUP_CYC) - 1);
  localparam logic [CntW-1:0] PulseLd = CntW'(eff_cyc(EN_HIGH_CYC) - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(eff_cyc(HOLD_CYC) - 1);
  localparam logic [CntW-1:0] CmdLd   = CntW'(eff_cyc(CMD_WAIT_CYC) - 1);
  localparam logic [CntW-1:0] ClearLd = CntW'(eff_cyc(CLEAR_WAIT_CYC) - 1);

`ifdef LCD_INIT_EN
  localparam logic [CntW-1:0] InitLd  = CntW'(eff_cyc(INIT_WAIT_CYC) - 1);
  localparam lcd_state_e      RstState = StInitWait;
  localparam logic [CntW-1:0] TmrRstVal = InitLd;
`else
  localparam lcd_state_e      RstState = StIdle;
  localparam logic [CntW-1:0] TmrRstVal = '0;
`endif

  lcd_state_e      state_q, state_d;
  logic            en_q, en_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_done;
  logic            handshake;

`ifdef LCD_INIT_EN
  logic [2:0]      init_idx_q, init_idx_d;
  logic [2:0]      init_idx_nxt;
  logic            init_done_q, init_done_d;
`endif

  lcd_timer #(
    .Width    (CntW),
    .ResetVal (TmrRstVal)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Ready only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready_o = (state_q == StIdle) && rst_ni;
    busy_o      = (state_q != StIdle);
    handshake   = req_valid_i && req_ready_o;
  end

`ifdef LCD_INIT_EN
  // Init progress is exported as a sticky flag.
  always_comb begin
    init_done_o  = init_done_q;
    init_idx_nxt = init_idx_q + 3'd1;
  end
`else
  // Without the init sequence the display is assumed ready from reset.
  always_comb begin
    init_done_o = 1'b1;
  end
`endif

  // Next-state logic: every state exit reloads the shared timer for the next state.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    rs_d     = rs_q;
    data_d   = data_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef LCD_INIT_EN
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
`endif

    unique case (state_q)
`ifdef LCD_INIT_EN
      StInitWait: begin
        if (tmr_done) begin
          rs_d       = 1'b0;
          data_d     = LCD_INIT_SEQ[0];
          init_idx_d = 3'd0;
          state_d    = StSetup;
          tmr_load   = 1'b1;
          tmr_val    = SetupLd;
        end
      end
`endif
      StIdle: begin
        if (handshake) begin
          rs_d     = req_rs_i;
          data_d   = req_data_i;
          state_d  = StSetup;
          tmr_load = 1'b1;
          tmr_val  = SetupLd;
        end
      end
      StSetup: begin
        if (tmr_done) begin
          en_d     = 1'b1;
          state_d  = StPulse;
          tmr_load = 1'b1;
          tmr_val  = PulseLd;
        end
      end
      StPulse: begin
        if (tmr_done) begin
          en_d     = 1'b0;
          state_d  = StHold;
          tmr_load = 1'b1;
          tmr_val  = HoldLd;
        end
      end
      StHold: begin
        if (tmr_done) begin
          state_d  = StExecWait;
          tmr_load = 1'b1;
          tmr_val  = is_slow_cmd(rs_q, data_q) ? ClearLd : CmdLd;
        end
      end
      StExecWait: begin
        if (tmr_done) begin
`ifdef LCD_INIT_EN
          // Until init completes, each finished byte chains straight into the next.
          if (!init_done_q) begin
            if (init_idx_q == 3'(LCD_INIT_LEN - 1)) begin
              init_done_d = 1'b1;
              state_d     = StIdle;
            end else begin
              init_idx_d = init_idx_nxt;
              rs_d       = 1'b0;
              data_d     = LCD_INIT_SEQ[init_idx_nxt];
              state_d    = StSetup;
              tmr_load   = 1'b1;
              tmr_val    = SetupLd;
            end
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = RstState;
      end
    endcase
  end

  // State and LCD pin registers; RS/DATA stay latched after the transfer ends.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RstState;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

`ifdef LCD_INIT_EN
  // Init sequencing registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      init_idx_q  <= 3'd0;
      init_done_q <= 1'b0;
    end else begin
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
    end
  end
`endif

  // Assemble the packed pin word; RW is tied low since the driver is write-only.
  always_comb begin
    lcd_o             = '0;
    lcd_o[LCD_ON_BIT] = 1'b1;
    lcd_o[LCD_EN_BIT] = en_q;
    lcd_o[LCD_RS_BIT] = rs_q;
    lcd_o[LCD_RW_BIT] = 1'b0;
    lcd_o[7:0]        = data_q;
  end

endmodule

// File: tb/tb_lcd_char_driver.sv
// Self-checking bench for lcd_char_driver with short simulation timings.
// A scoreboard queue holds the bytes expected on each EN pulse; a negedge
// monitor pops and checks them, while scenario tasks check timing and handshakes.
module tb_lcd_char_driver;

  localparam int unsigned SETUP = 2;
  localparam int unsigned ENH   = 4;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned CMDW  = 10;
  localparam int unsigned CLRW  = 30;
  localparam int unsigned INITW = 20;
  localparam int FAST = SETUP + ENH + HOLD + CMDW + 1;  // 19
  localparam int SLOW = SETUP + ENH + HOLD + CLRW + 1;  // 39

`ifdef LCD_INIT_EN
  localparam logic RST_BUSY = 1'b1;
  localparam logic RST_DONE = 1'b0;
`else
  localparam logic RST_BUSY = 1'b0;
  localparam logic RST_DONE = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic        rs = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        busy;
  logic        init_done;
  logic [31:0] lcd;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int release_cyc = 0;
  logic [8:0] exp_q[$];
  int rise_t[$];
  bit skip_len = 1'b0;

  lcd_char_driver #(
    .SETUP_CYC      (SETUP),
    .EN_HIGH_CYC    (ENH),
    .HOLD_CYC       (HOLD),
    .CMD_WAIT_CYC   (CMDW),
    .CLEAR_WAIT_CYC (CLRW),
    .INIT_WAIT_CYC  (INITW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (valid),
    .req_ready_o (ready),
    .req_rs_i    (rs),
    .req_data_i  (data),
    .busy_o      (busy),
    .init_done_o (init_done),
    .lcd_o       (lcd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // EN pulse monitor / scoreboard consumer.
  logic        en_prev = 1'b0;
  int          en_len = 0;
  logic [31:0] exp_word = 32'h8000_0000;
  logic [8:0]  mon_e;
  always @(negedge clk) begin
    if (lcd[10] === 1'b1 && en_prev !== 1'b1) begin
      pulses++;
      rise_t.push_back(cyc);
      en_len = 1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        exp_word = lcd & ~32'h0000_0400;
        $display("FAIL pulse_unexpected: lcd_o=%h with no byte pending", lcd);
      end else begin
        mon_e = exp_q.pop_front();
        exp_word = 32'h8000_0000 | (32'(mon_e[8]) << 9) | 32'(mon_e[7:0]);
        if (lcd !== (exp_word | 32'h0000_0400)) begin
          bad++;
          $display("FAIL pulse_word: got %h want %h", lcd, exp_word | 32'h0000_0400);
        end
      end
    end else if (lcd[10] === 1'b1) begin
      en_len++;
    end else if (en_prev === 1'b1) begin
      if (skip_len) begin
        skip_len = 1'b0;
      end else begin
        total++;
        if (en_len != ENH || lcd !== exp_word) begin
          bad++;
          $display("FAIL pulse_end: en_len=%0d lcd_o=%h want len=%0d lcd_o=%h",
                   en_len, lcd, ENH, exp_word);
        end
      end
    end
    en_prev = lcd[10];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

`ifdef LCD_INIT_EN
  task automatic push_init;
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask
`endif

  // Drives one handshake (ready assumed high) and counts negedges until ready returns.
  task automatic run_byte(input logic b_rs, input logic [7:0] b_data, output int n);
    valid = 1'b1;
    rs = b_rs;
    data = b_data;
    exp_q.push_back({b_rs, b_data});
    @(negedge clk);
    valid = 1'b0;
    n = 1;
    while (ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (lcd !== 32'h8000_0000) begin
      bad++; $display("FAIL reset_lcd: got %h want 80000000", lcd);
    end
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    total++;
    if (busy !== RST_BUSY) begin
      bad++; $display("FAIL reset_busy: got %b want %b", busy, RST_BUSY);
    end
    total++;
    if (init_done !== RST_DONE) begin
      bad++; $display("FAIL reset_init_done: got %b want %b", init_done, RST_DONE);
    end
    pulses = 0;
    rise_t.delete();
    rst_n = 1'b1;
    release_cyc = cyc;
`ifdef LCD_INIT_EN
    push_init();
`else
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: ready=%b busy=%b want 1 0", ready, busy);
    end
`endif
  endtask

`ifdef LCD_INIT_EN
  task automatic test_init;
    int n;
    wait_init(n);
    total++;
    if (init_done !== 1'b1) begin
      bad++; $display("FAIL init_timeout: init_done=%b want 1", init_done);
    end
    total++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL init_idle: ready=%b busy=%b want 1 0", ready, busy);
    end
    total++;
    if (pulses != 6) begin
      bad++; $display("FAIL init_pulses: got %0d want 6", pulses);
    end
    if (rise_t.size() >= 6) begin
      total++;
      if (rise_t[0] - release_cyc != int'(INITW + SETUP)) begin
        bad++; $display("FAIL init_first: got %0d want %0d", rise_t[0] - release_cyc, INITW + SETUP);
      end
      total++;
      if (rise_t[1] - rise_t[0] != int'(ENH + HOLD + CMDW + SETUP)) begin
        bad++; $display("FAIL init_gap_cmd: got %0d want %0d", rise_t[1] - rise_t[0], ENH + HOLD + CMDW + SETUP);
      end
      total++;
      if (rise_t[5] - rise_t[4] != int'(ENH + HOLD + CLRW + SETUP)) begin
        bad++; $display("FAIL init_gap_clear: got %0d want %0d", rise_t[5] - rise_t[4], ENH + HOLD + CLRW + SETUP);
      end
    end
  endtask
`endif

  task automatic test_single;
    logic [31:0] want;
    int n;
    valid = 1'b1; rs = 1'b1; data = 8'h41;
    exp_q.push_back({1'b1, 8'h41});
    @(negedge clk);
    valid = 1'b0; rs = 1'b0; data = 8'h00;
    total++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL single_busy: ready=%b busy=%b want 0 1", ready, busy);
    end
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      want = (k >= 3 && k <= 6) ? 32'h8000_0641 : 32'h8000_0241;
      total++;
      if (lcd !== want) begin
        bad++; $display("FAIL single_wave cycle %0d: got %h want %h", k, lcd, want);
      end
    end
    n = 8;
    while (ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != FAST) begin
      bad++; $display("FAIL single_ready: ready after %0d want %0d", n, FAST);
    end
    total++;
    if (lcd !== 32'h8000_0241 || busy !== 1'b0) begin
      bad++; $display("FAIL single_retain: lcd_o=%h busy=%b want 80000241 0", lcd, busy);
    end
  endtask

  task automatic test_exec_wait;
    logic [8:0] bytes [7];
    int         want [7];
    int         n;
    bytes = '{{1'b0, 8'h01}, {1'b0, 8'h80}, {1'b0, 8'h02}, {1'b0, 8'h03},
              {1'b0, 8'h04}, {1'b1, 8'h01}, {1'b0, 8'h00}};
    want  = '{SLOW, FAST, SLOW, SLOW, FAST, FAST, FAST};
    for (int i = 0; i < 7; i++) begin
      run_byte(bytes[i][8], bytes[i][7:0], n);
      total++;
      if (n != want[i]) begin
        bad++; $display("FAIL exec_wait rs=%b data=%h: ready after %0d want %0d",
                        bytes[i][8], bytes[i][7:0], n, want[i]);
      end
    end
  endtask

  task automatic test_held_valid;
    int n;
    valid = 1'b1; rs = 1'b0; data = 8'h80;
    exp_q.push_back({1'b0, 8'h80});
    @(negedge clk);
    rs = 1'b1; data = 8'h90;
    exp_q.push_back({1'b1, 8'h90});
    n = 1;
    while (ready !== 1'b1 && n < 300) begin
      total++;
      if (lcd[7:0] !== 8'h80) begin
        bad++; $display("FAIL held_data_stable: got %h want 80", lcd[7:0]);
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (n != FAST) begin
      bad++; $display("FAIL held_idle_cycle: ready after %0d want %0d", n, FAST);
    end
    @(negedge clk);
    valid = 1'b0;
    total++;
    if (ready !== 1'b0 || lcd !== 32'h8000_0290) begin
      bad++; $display("FAIL held_accept: ready=%b lcd_o=%h want 0 80000290", ready, lcd);
    end
    n = 1;
    while (ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != FAST) begin
      bad++; $display("FAIL held_second: ready after %0d want %0d", n, FAST);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit early;
    valid = 1'b1; rs = 1'b1; data = 8'h48;
    exp_q.push_back({1'b1, 8'h48});
    @(negedge clk);
    data = 8'h49;
    exp_q.push_back({1'b1, 8'h49});
    n = 1;
    early = 1'b0;
    while (ready !== 1'b1 && n < 300) begin
      if (lcd[7:0] !== 8'h48) early = 1'b1;
      @(negedge clk);
      n++;
    end
    total++;
    if (early) begin
      bad++; $display("FAIL b2b_early_data: second byte visible early (early=%b want 0)", early);
    end
    @(negedge clk);
    valid = 1'b0;
    n = 1;
    while (ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rise_t.size() < 2 || rise_t[$] - rise_t[$-1] != FAST) begin
      bad++; $display("FAIL b2b_gap: got %0d want %0d",
                      (rise_t.size() < 2) ? -1 : rise_t[$] - rise_t[$-1], FAST);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit en_seen;
    valid = 1'b1; rs = 1'b1; data = 8'h55;
    exp_q.push_back({1'b1, 8'h55});
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (lcd[10] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (lcd[10] !== 1'b1) begin
      bad++; $display("FAIL rstmid_no_pulse: en=%b want 1", lcd[10]);
    end
    @(negedge clk);
    skip_len = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (lcd !== 32'h8000_0000 || ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_lcd: lcd_o=%h ready=%b want 80000000 0", lcd, ready);
    end
    rst_n = 1'b1;
`ifdef LCD_INIT_EN
    push_init();
`endif
    en_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (lcd[10] !== 1'b0) en_seen = 1'b1;
    end
    total++;
    if (en_seen) begin
      bad++; $display("FAIL rstmid_repulse: en_seen=%b want 0", en_seen);
    end
`ifdef LCD_INIT_EN
    wait_init(n);
`endif
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_ready: got %b want 1", ready);
    end
  endtask

  task automatic test_ignored_valid;
    int n;
    int p0;
    p0 = pulses;
    valid = 1'b1; rs = 1'b1; data = 8'h31;
    exp_q.push_back({1'b1, 8'h31});
    @(negedge clk);
    n = 1;
    while (ready !== 1'b1 && n < 300) begin
      valid = ~valid;
      rs = 1'b0;
      data = 8'hAA ^ 8'(n);
      total++;
      if ((lcd & ~32'h0000_0400) !== 32'h8000_0231) begin
        bad++; $display("FAIL ignored_lcd: got %h want 80000231 (EN masked)", lcd);
      end
      @(negedge clk);
      n++;
    end
    valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (pulses - p0 != 1) begin
      bad++; $display("FAIL ignored_pulses: got %0d want 1", pulses - p0);
    end
    total++;
    if (ready !== 1'b1 || lcd !== 32'h8000_0231) begin
      bad++; $display("FAIL ignored_idle: ready=%b lcd_o=%h want 1 80000231", ready, lcd);
    end
  endtask

  initial begin
    test_reset();
`ifdef LCD_INIT_EN
    test_init();
`endif
    test_single();
    test_exec_wait();
    test_held_valid();
    test_back_to_back();
    test_reset_mid();
    test_ignored_valid();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d bytes never pulsed, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
